// File: rtl/clkgt_ctrl_pkg.sv
// Shared types and widths for the clock-gate enable controller.
package clkgt_ctrl_pkg;

  typedef enum logic [1:0] {
    ON   = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_e;

  localparam int unsigned IDLE_W       = 8;
  localparam int unsigned WAKE_W       = 4;
  localparam int unsigned PERF_GATED_W = 32;
  localparam int unsigned PERF_WAKE_W  = 16;

endpackage

// File: rtl/clkgt_ctrl_if.sv
// Request/activity and gate-cell control bundle of clkgt_ctrl.
// master = bank/software side driving activity, slave = the controller.
interface clkgt_ctrl_if;
  import clkgt_ctrl_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic                    busy;
  logic                    force_on;
  logic                    test_en;
  logic                    cg_en;
  logic                    cg_te;
  logic                    gated;
  logic [PERF_GATED_W-1:0] perf_gated_cycles;
  logic [PERF_WAKE_W-1:0]  perf_wake_events;

  modport master (
    output req_valid, busy, force_on, test_en,
    input  req_ready, cg_en, cg_te, gated, perf_gated_cycles, perf_wake_events
  );

  modport slave (
    input  req_valid, busy, force_on, test_en,
    output req_ready, cg_en, cg_te, gated, perf_gated_cycles, perf_wake_events
  );

endinterface

// File: rtl/clkgt_ctrl_perf.sv
// Saturating counters of cycles spent gated and of wake-ups.
// Only instantiated when CLKGT_CTRL_PERF_EN is defined.
module clkgt_ctrl_perf
  import clkgt_ctrl_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_off,
  input  logic                    i_wake_evt,
  output logic [PERF_GATED_W-1:0] o_gated_cycles,
  output logic [PERF_WAKE_W-1:0]  o_wake_events
);

  logic [PERF_GATED_W-1:0] r_gated_cycles;
  logic [PERF_WAKE_W-1:0]  r_wake_events;

  // Both counters hold at all-ones rather than wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gated_cycles <= '0;
      r_wake_events  <= '0;
    end else begin
      if (i_in_off && (r_gated_cycles != {PERF_GATED_W{1'b1}}))
        r_gated_cycles <= r_gated_cycles + PERF_GATED_W'(1);
      if (i_wake_evt && (r_wake_events != {PERF_WAKE_W{1'b1}}))
        r_wake_events <= r_wake_events + PERF_WAKE_W'(1);
    end
  end

  assign o_gated_cycles = r_gated_cycles;
  assign o_wake_events  = r_wake_events;

endmodule

// File: rtl/clkgt_ctrl.sv
// Clock-gate enable controller: gates the bank after an idle window and
// runs a counted wake-up before granting access. Perf counters: CLKGT_CTRL_PERF_EN.
module clkgt_ctrl
  import clkgt_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  clkgt_ctrl_if.slave  io_bus
);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  state_e            r_state;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [WAKE_W-1:0] r_wake_cnt;
  logic              r_cg_en;
  logic              r_req_ready;
  logic              r_gated;
  logic              w_act;

  assign w_act = io_bus.req_valid | io_bus.busy | io_bus.force_on | io_bus.test_en;

  // Outputs are loaded alongside the next state so they always match r_state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ON;
      r_idle_cnt  <= '0;
      r_wake_cnt  <= '0;
      r_cg_en     <= 1'b1;
      r_req_ready <= 1'b1;
      r_gated     <= 1'b0;
    end else begin
      case (r_state)
        ON: begin
          if (w_act) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_state     <= OFF;
            r_idle_cnt  <= '0;
            r_cg_en     <= 1'b0;
            r_req_ready <= 1'b0;
            r_gated     <= 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end
        OFF: begin
          if (w_act) begin
            r_state    <= WAKE;
            r_wake_cnt <= '0;
            r_cg_en    <= 1'b1;
            r_gated    <= 1'b0;
          end
        end
        WAKE: begin
          // Wake runs to completion regardless of activity
          if (r_wake_cnt == WAKE_LAST) begin
            r_state     <= ON;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            r_req_ready <= 1'b1;
          end else begin
            r_wake_cnt <= r_wake_cnt + WAKE_W'(1);
          end
        end
        default: begin
          r_state     <= ON;
          r_idle_cnt  <= '0;
          r_wake_cnt  <= '0;
          r_cg_en     <= 1'b1;
          r_req_ready <= 1'b1;
          r_gated     <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.cg_en     = r_cg_en;
  assign io_bus.req_ready = r_req_ready;
  assign io_bus.gated     = r_gated;
  assign io_bus.cg_te     = io_bus.test_en;

`ifdef CLKGT_CTRL_PERF_EN
  logic w_in_off;
  logic w_wake_evt;

  assign w_in_off   = (r_state == OFF);
  assign w_wake_evt = (r_state == OFF) && w_act;

  clkgt_ctrl_perf u_perf (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_in_off       (w_in_off),
    .i_wake_evt     (w_wake_evt),
    .o_gated_cycles (io_bus.perf_gated_cycles),
    .o_wake_events  (io_bus.perf_wake_events)
  );
`else
  assign io_bus.perf_gated_cycles = '0;
  assign io_bus.perf_wake_events  = '0;
`endif

endmodule
